// File: rtl/spi_pkg.sv
// Shared types and defaults for the mode-0 SPI master and its companion slave bench.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      HOLD,
      GAP
   } state_t;

   localparam bit CPOL = 1'b0;
   localparam bit CPHA = 1'b0;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/spi_master_fsm_if.sv
// Core-side handshake plus SPI pins of the master; master modport is the DUT view.
interface spi_master_fsm_if
   import spi_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);

   logic              start;
   logic [DATA_W-1:0] tx_data;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] rx_data;
   logic              sclk;
   logic              cs;
   logic              mosi;
   logic              miso;

   modport master (
      input  start, tx_data, miso,
      output busy, done, rx_data, sclk, cs, mosi
   );

   modport slave (
      output start, tx_data, miso,
      input  busy, done, rx_data, sclk, cs, mosi
   );

endinterface

// File: rtl/spi_phase_timer.sv
// Divides clk into sclk half-periods; phase_end marks the last clk of each phase.
module spi_phase_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic phase_end
);

   localparam int               CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] div_cnt;

   // Held at zero while idle so every frame starts with a full-length phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (!run || div_cnt == LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
      end
   end

   assign phase_end = run && (div_cnt == LAST);

endmodule

// File: rtl/spi_master_fsm.sv
// Mode-0 SPI master: one full-duplex DATA_W-bit frame per accepted start, MSB first.
module spi_master_fsm
   import spi_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input logic              clk,
   input logic              rst,
   spi_master_fsm_if.master bus
);

   localparam int               BIT_W    = $clog2(DATA_W);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   state_t            state;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] tx_sh;
   logic [DATA_W-1:0] rx_sh;
   logic              run;
   logic              phase_end;
   logic              accept;
   logic              sample;

   assign run = (state != IDLE);

   // A start still high when GAP expires opens the next frame directly, so
   // back-to-back frames see cs high for exactly one phase.
   assign accept = bus.start && ((state == IDLE) || (state == GAP && phase_end));

   assign sample = phase_end && (state == SETUP || state == LOW);

   spi_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .phase_end (phase_end)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         bus.sclk    <= 1'b0;
         bus.cs      <= 1'b1;
         bus.mosi    <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.rx_data <= '0;
      end else begin
         bus.done <= 1'b0;
         if (accept) begin
            bus.cs   <= 1'b0;
            bus.mosi <= bus.tx_data[DATA_W-1];
            bus.busy <= 1'b1;
            bit_cnt  <= LAST_BIT;
            state    <= SETUP;
         end else begin
            case (state)
               IDLE: ;
               SETUP: begin
                  if (phase_end) begin
                     bus.sclk <= 1'b1;
                     state    <= HIGH;
                  end
               end
               HIGH: begin
                  if (phase_end) begin
                     bus.sclk <= 1'b0;
                     if (bit_cnt == '0) begin
                        state <= HOLD;
                     end else begin
                        bus.mosi <= tx_sh[bit_cnt - BIT_W'(1)];
                        bit_cnt  <= bit_cnt - BIT_W'(1);
                        state    <= LOW;
                     end
                  end
               end
               LOW: begin
                  if (phase_end) begin
                     bus.sclk <= 1'b1;
                     state    <= HIGH;
                  end
               end
               HOLD: begin
                  if (phase_end) begin
                     bus.cs      <= 1'b1;
                     bus.mosi    <= 1'b0;
                     bus.rx_data <= rx_sh;
                     bus.done    <= 1'b1;
                     state       <= GAP;
                  end
               end
               GAP: begin
                  if (phase_end) begin
                     bus.busy <= 1'b0;
                     state    <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Shift registers carry payload only; control qualifies every use of them.
   always_ff @(posedge clk) begin
      if (accept) begin
         tx_sh <= bus.tx_data;
      end
      if (sample) begin
         rx_sh <= {rx_sh[DATA_W-2:0], bus.miso};
      end
   end

endmodule

// File: tb/tb_spi_master_fsm.sv
// Loopback bench: behavioural mode-0 slaves on an 8-bit/div-4 and a 16-bit/div-2 master.
module tb_spi_master_fsm;
   import spi_pkg::*;

   localparam int DW   = 8;
   localparam int CD   = 4;
   localparam int DW2  = 16;
   localparam int CD2  = 2;
   localparam int LAT  = (2 * DW + 1) * CD;
   localparam int LAT2 = (2 * DW2 + 1) * CD2;

   typedef struct {
      logic [DW-1:0] tx;
      logic [DW-1:0] sin;
      logic [DW-1:0] exp_rx;
      logic [DW-1:0] exp_cap;
   } vec_t;

   vec_t vecs[6];

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   spi_master_fsm_if #(.DATA_W(DW))  bus  ();
   spi_master_fsm_if #(.DATA_W(DW2)) bus2 ();

   spi_master_fsm #(.DATA_W(DW), .CLK_DIV(CD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   spi_master_fsm #(.DATA_W(DW2), .CLK_DIV(CD2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   // 8-bit mode-0 slave: preload on cs fall, capture on sclk rise, shift on sclk fall.
   logic [DW-1:0] s_in = '0;
   logic [DW-1:0] s_sh = '0;
   logic [DW-1:0] s_cap = '0;
   int            s_rises = 0;
   logic          p_cs = 1'b1;
   logic          p_sclk = 1'b0;

   always @(bus.cs or bus.sclk) begin
      if (p_cs === 1'b1 && bus.cs === 1'b0) begin
         s_sh    = s_in;
         s_rises = 0;
      end else if (bus.cs === 1'b0 && p_sclk === 1'b0 && bus.sclk === 1'b1) begin
         s_cap   = {s_cap[DW-2:0], bus.mosi};
         s_rises = s_rises + 1;
      end else if (bus.cs === 1'b0 && p_sclk === 1'b1 && bus.sclk === 1'b0) begin
         s_sh = {s_sh[DW-2:0], 1'b0};
      end
      p_cs   = bus.cs;
      p_sclk = bus.sclk;
   end

   assign bus.miso = bus.cs ? 1'bx : s_sh[DW-1];

   // 16-bit slave of the same behaviour.
   logic [DW2-1:0] s2_in = '0;
   logic [DW2-1:0] s2_sh = '0;
   logic [DW2-1:0] s2_cap = '0;
   int             s2_rises = 0;
   logic           p2_cs = 1'b1;
   logic           p2_sclk = 1'b0;

   always @(bus2.cs or bus2.sclk) begin
      if (p2_cs === 1'b1 && bus2.cs === 1'b0) begin
         s2_sh    = s2_in;
         s2_rises = 0;
      end else if (bus2.cs === 1'b0 && p2_sclk === 1'b0 && bus2.sclk === 1'b1) begin
         s2_cap   = {s2_cap[DW2-2:0], bus2.mosi};
         s2_rises = s2_rises + 1;
      end else if (bus2.cs === 1'b0 && p2_sclk === 1'b1 && bus2.sclk === 1'b0) begin
         s2_sh = {s2_sh[DW2-2:0], 1'b0};
      end
      p2_cs   = bus2.cs;
      p2_sclk = bus2.sclk;
   end

   assign bus2.miso = bus2.cs ? 1'bx : s2_sh[DW2-1];

   // Pin monitor: idle-pin rule, done pulses, cs-low and cs-high run lengths.
   int mon_bad = 0;
   int done_cnt = 0;
   int low_run = 0;
   int high_run = 0;
   int last_low = 0;
   int last_high = 0;

   always @(negedge clk) begin
      if (bus.cs === 1'b1) begin
         if (bus.sclk !== 1'b0 || bus.mosi !== 1'b0) mon_bad = mon_bad + 1;
         high_run = high_run + 1;
         if (low_run != 0) begin
            last_low = low_run;
            low_run  = 0;
         end
      end else if (bus.cs === 1'b0) begin
         low_run = low_run + 1;
         if (high_run != 0) begin
            last_high = high_run;
            high_run  = 0;
         end
      end
      if (bus2.cs === 1'b1 && (bus2.sclk !== 1'b0 || bus2.mosi !== 1'b0)) mon_bad = mon_bad + 1;
      if (bus.done === 1'b1) done_cnt = done_cnt + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Ends at E0+#1, where E0 is the edge that accepts the start.
   task automatic launch(input logic [DW-1:0] tx, input logic [DW-1:0] sin, input bit hold);
      s_in = sin;
      @(negedge clk);
      bus.tx_data = tx;
      bus.start   = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
   endtask

   // Counts clk edges after E0 until done; optionally re-pulses start mid-frame.
   task automatic wait_done(output int lat, input int inject_at, input logic [DW-1:0] inject_tx);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 4 * LAT) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == inject_at) begin
            bus.tx_data = inject_tx;
            bus.start   = 1'b1;
         end else if (inject_at > 0 && lat == inject_at + 1) begin
            bus.start = 1'b0;
         end
      end
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy !== 1'b0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run_frame(input string tag, input logic [DW-1:0] tx, input logic [DW-1:0] sin,
                            input logic [DW-1:0] exp_rx, input logic [DW-1:0] exp_cap);
      int lat;
      int n;
      int d0;
      d0 = done_cnt;
      launch(tx, sin, 1'b0);
      check($sformatf("%s_busy_rise", tag), 64'(bus.busy), 64'd1);
      check($sformatf("%s_cs_fall", tag), 64'(bus.cs), 64'd0);
      wait_done(lat, -1, '0);
      check($sformatf("%s_done_latency", tag), 64'(lat), 64'(LAT));
      check($sformatf("%s_rx_data", tag), 64'(bus.rx_data), 64'(exp_rx));
      check($sformatf("%s_slave_capture", tag), 64'(s_cap), 64'(exp_cap));
      check($sformatf("%s_sclk_rises", tag), 64'(s_rises), 64'(DW));
      wait_idle(n);
      check($sformatf("%s_busy_after_done", tag), 64'(n), 64'(CD));
      check($sformatf("%s_done_pulses", tag), 64'(done_cnt - d0), 64'd1);
      check($sformatf("%s_cs_low_clks", tag), 64'(last_low), 64'(LAT));
   endtask

   initial begin
      int lat;
      int n;
      int d0;
      logic [DW-1:0] rtx;
      logic [DW-1:0] rsin;

      vecs[0] = '{tx: 8'hA5, sin: 8'h3C, exp_rx: 8'h3C, exp_cap: 8'hA5};
      vecs[1] = '{tx: 8'hFF, sin: 8'h00, exp_rx: 8'h00, exp_cap: 8'hFF};
      vecs[2] = '{tx: 8'h00, sin: 8'hFF, exp_rx: 8'hFF, exp_cap: 8'h00};
      vecs[3] = '{tx: 8'h80, sin: 8'h01, exp_rx: 8'h01, exp_cap: 8'h80};
      vecs[4] = '{tx: 8'h01, sin: 8'h80, exp_rx: 8'h80, exp_cap: 8'h01};
      vecs[5] = '{tx: 8'h5A, sin: 8'hA5, exp_rx: 8'hA5, exp_cap: 8'h5A};

      bus.start    = 1'b0;
      bus.tx_data  = '0;
      bus2.start   = 1'b0;
      bus2.tx_data = '0;

      #1 rst = 1'b1;
      #1;
      check("rst_cs", 64'(bus.cs), 64'd1);
      check("rst_sclk", 64'(bus.sclk), 64'd0);
      check("rst_mosi", 64'(bus.mosi), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_rx_data", 64'(bus.rx_data), 64'd0);
      check("rst_cs_16", 64'(bus2.cs), 64'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].tx, vecs[i].sin, vecs[i].exp_rx, vecs[i].exp_cap);
      end

      // Start re-pulsed mid-frame with different data must be ignored.
      d0 = done_cnt;
      launch(8'hA5, 8'h3C, 1'b0);
      wait_done(lat, 10, 8'h11);
      check("guard_latency", 64'(lat), 64'(LAT));
      check("guard_slave_capture", 64'(s_cap), 64'hA5);
      check("guard_rx_data", 64'(bus.rx_data), 64'h3C);
      wait_idle(n);
      repeat (LAT) @(posedge clk);
      #1;
      check("guard_single_done", 64'(done_cnt - d0), 64'd1);
      check("guard_no_queue", 64'(bus.busy), 64'd0);

      // Start held high: the second frame opens as soon as GAP ends.
      d0 = done_cnt;
      launch(8'h96, 8'h3C, 1'b1);
      wait_done(lat, -1, '0);
      check("b2b_first_latency", 64'(lat), 64'(LAT));
      check("b2b_first_rx", 64'(bus.rx_data), 64'h3C);
      check("b2b_first_capture", 64'(s_cap), 64'h96);
      s_in        = 8'h5A;
      bus.tx_data = 8'h69;
      n = 0;
      while (bus.cs !== 1'b0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      bus.start = 1'b0;
      check("b2b_restart_delay", 64'(n), 64'(CD));
      wait_done(lat, -1, '0);
      check("b2b_second_latency", 64'(lat), 64'(LAT));
      check("b2b_second_rx", 64'(bus.rx_data), 64'h5A);
      check("b2b_second_capture", 64'(s_cap), 64'h69);
      wait_idle(n);
      check("b2b_cs_high_gap", 64'(last_high), 64'(CD));
      check("b2b_done_pulses", 64'(done_cnt - d0), 64'd2);

      // Reset 30 clks into a frame.
      d0 = done_cnt;
      launch(8'hE7, 8'h18, 1'b0);
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_cs", 64'(bus.cs), 64'd1);
      check("midrst_sclk", 64'(bus.sclk), 64'd0);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_rx_data", 64'(bus.rx_data), 64'd0);
      check("midrst_mosi", 64'(bus.mosi), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (LAT + 10) @(posedge clk);
      #1;
      check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
      run_frame("after_rst", 8'hC3, 8'h96, 8'h96, 8'hC3);

      // Random frames against the loopback rule: master receives what the slave held and vice versa.
      for (int i = 0; i < 12; i++) begin
         rtx  = DW'($urandom);
         rsin = DW'($urandom);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         run_frame($sformatf("rand%0d", i), rtx, rsin, rsin, rtx);
      end

      // 16-bit, divide-by-2 instance.
      s2_in = 16'h8421;
      @(negedge clk);
      bus2.tx_data = 16'hBEEF;
      bus2.start   = 1'b1;
      @(posedge clk);
      #1 bus2.start = 1'b0;
      lat = 0;
      while (bus2.done !== 1'b1 && lat < 4 * LAT2) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("w16_done_latency", 64'(lat), 64'(LAT2));
      check("w16_rx_data", 64'(bus2.rx_data), 64'h8421);
      check("w16_slave_capture", 64'(s2_cap), 64'hBEEF);
      check("w16_sclk_rises", 64'(s2_rises), 64'(DW2));
      repeat (10) @(posedge clk);
      #1;
      check("w16_idle", 64'(bus2.busy), 64'd0);

      check("idle_pin_violations", 64'(mon_bad), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
